// File: rtl/ifetch32_pkg.sv
// Shared definitions for the ifetch32 fetch stage: FSM states, the nop
// constant and instruction field positions used by the next-PC logic.
package ifetch32_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;
    localparam int TGT26_MSB = 25;
    localparam int TGT26_LSB = 0;

    // Branch displacement in bytes: sign-extended word offset shifted left by two.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch32_prgrom.sv
// Program memory: synchronous write port for the boot loader and an
// asynchronous read port for instruction fetch.
module prgrom #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifetch32.sv
// Instruction fetch for the single-cycle MIPS core: boot-loads program memory,
// then owns the PC and selects the next PC from the controller's jump/branch flags.
module ifetch32
    import ifetch32_pkg::*;
#(
    parameter int          IMEM_AW  = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_done,
    output logic        ld_ready,
    output logic        ld_overflow,
    output logic        inited,
    output logic [31:0] Instruction,
    output logic [31:0] pc,
    output logic [31:0] link_addr
);

    state_t            r_state;
    state_t            w_state_nxt;
    // One extra bit so the counter can reach 2^IMEM_AW and signal "memory full".
    logic [IMEM_AW:0]  r_la;
    logic              r_ovf;
    logic [31:0]       r_pc;

    logic              w_ld_ready;
    logic              w_ld_we;
    logic [31:0]       w_rdata;
    logic [31:0]       w_pc4;
    logic [31:0]       w_jr_tgt;
    logic [31:0]       w_j_tgt;
    logic [31:0]       w_br_tgt;
    logic              w_br_taken;
    logic [31:0]       w_pc_nxt;

    assign w_ld_ready = (r_state == ST_LOAD) && !r_la[IMEM_AW];
    assign w_ld_we    = ld_valid && w_ld_ready;

    prgrom #(
        .AW (IMEM_AW)
    ) u_prgrom (
        .clk     (clk),
        .i_we    (w_ld_we),
        .i_waddr (r_la[IMEM_AW-1:0]),
        .i_wdata (ld_data),
        .i_raddr (r_pc[IMEM_AW+1:2]),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: if (ld_done) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_la    <= '0;
            r_ovf   <= 1'b0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_we) begin
                r_la <= r_la + 1'b1;
            end
            if ((r_state == ST_LOAD) && ld_valid && r_la[IMEM_AW]) begin
                r_ovf <= 1'b1;
            end
            // PC is frozen through LOAD, including the edge that samples ld_done.
            r_pc <= (r_state == ST_RUN) ? w_pc_nxt : RESET_PC;
        end
    end

    assign Instruction = (r_state == ST_RUN) ? w_rdata : NOP_INSTR;

    assign w_pc4      = r_pc + 32'd4;
    assign w_jr_tgt   = Read_data_1 & 32'hFFFF_FFFC;
    assign w_j_tgt    = {w_pc4[31:28], Instruction[TGT26_MSB:TGT26_LSB], 2'b00};
    assign w_br_tgt   = w_pc4 + branch_offset(Instruction[IMM16_MSB:IMM16_LSB]);
    assign w_br_taken = (Branch && Zero) || (nBranch && !Zero);

    always_comb begin
        w_pc_nxt = w_pc4;
        if (Jr) begin
            w_pc_nxt = w_jr_tgt;
        end else if (Jmp || Jal) begin
            w_pc_nxt = w_j_tgt;
        end else if (w_br_taken) begin
            w_pc_nxt = w_br_tgt;
        end
    end

    assign ld_ready    = w_ld_ready;
    assign ld_overflow = r_ovf;
    assign inited      = (r_state == ST_RUN);
    assign pc          = r_pc;
    assign link_addr   = w_pc4;

endmodule
